// File: rtl/adder7_err_monitor.sv
// Streaming error monitor for an approximate 7-input popcount adder.
// Optional histogram of absolute errors is enabled with macro ERR_HIST_EN.
module adder7_err_monitor #(
   parameter int WINDOW = 256,
   parameter int CNT_W  = 16,
   parameter int SUM_W  = 20
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [6:0]       i_in_vec,
   input  logic [3:0]       i_in_approx,
   output logic             o_busy,
   output logic             o_done,
   output logic [CNT_W-1:0] o_sample_cnt,
   output logic [CNT_W-1:0] o_err_cnt,
   output logic [SUM_W-1:0] o_err_sum,
   output logic [3:0]       o_err_max
`ifdef ERR_HIST_EN
   ,
   input  logic [2:0]       i_hist_sel,
   output logic [CNT_W-1:0] o_hist_cnt
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_acc_cnt;
   logic             r_in_ready;
   logic             r_busy;
   logic             r_done;
   logic             r_vld_p1;
   logic [3:0]       r_abs_err_p1;
   logic [CNT_W-1:0] r_sample_cnt;
   logic [CNT_W-1:0] r_err_cnt;
   logic [SUM_W-1:0] r_err_sum;
   logic [3:0]       r_err_max;

   logic w_accept;
   logic w_clear;
   logic w_last;

   function automatic logic [3:0] popcount7(input logic [6:0] v);
      logic [3:0] c;
      c = '0;
      for (int i = 0; i < 7; i++) c = c + {3'b000, v[i]};
      return c;
   endfunction

   function automatic logic [3:0] abs_diff(input logic [3:0] approx, input logic [3:0] exact);
      logic signed [4:0] d;
      d = $signed({1'b0, approx}) - $signed({1'b0, exact});
      return (d < 0) ? 4'(-d) : 4'(d);
   endfunction

   function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] acc, input logic [3:0] e);
      logic [SUM_W:0] s;
      s = {1'b0, acc} + {{(SUM_W-3){1'b0}}, e};
      return s[SUM_W] ? {SUM_W{1'b1}} : s[SUM_W-1:0];
   endfunction

   assign w_accept = r_in_ready & i_in_valid;
   assign w_clear  = i_start & ((r_state == S_IDLE) | (r_state == S_DONE));
   assign w_last   = w_accept & (r_acc_cnt == CNT_W'(WINDOW - 1));

   // Control FSM with registered handshake/status outputs
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_acc_cnt  <= '0;
         r_in_ready <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (i_start) begin
                  r_state    <= S_RUN;
                  r_acc_cnt  <= '0;
                  r_in_ready <= 1'b1;
                  r_busy     <= 1'b1;
                  r_done     <= 1'b0;
               end
            end
            S_RUN: begin
               if (w_accept) r_acc_cnt <= r_acc_cnt + CNT_W'(1);
               if (w_last) begin
                  r_state    <= S_DRAIN;
                  r_in_ready <= 1'b0;
               end
            end
            S_DRAIN: begin
               if (!r_vld_p1) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: begin
               r_state    <= S_IDLE;
               r_in_ready <= 1'b0;
               r_busy     <= 1'b0;
               r_done     <= 1'b0;
            end
         endcase
      end
   end

   // Stage 1: exact count and absolute error
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_vld_p1 <= 1'b0;
      else       r_vld_p1 <= w_accept;
   end

   always_ff @(posedge i_clk) begin
      if (w_accept) r_abs_err_p1 <= abs_diff(i_in_approx, popcount7(i_in_vec));
   end

   // Stage 2: accumulators
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sample_cnt <= '0;
         r_err_cnt    <= '0;
         r_err_sum    <= '0;
         r_err_max    <= '0;
      end else if (w_clear) begin
         r_sample_cnt <= '0;
         r_err_cnt    <= '0;
         r_err_sum    <= '0;
         r_err_max    <= '0;
      end else if (r_vld_p1) begin
         r_sample_cnt <= r_sample_cnt + CNT_W'(1);
         if (r_abs_err_p1 != 4'd0) r_err_cnt <= r_err_cnt + CNT_W'(1);
         r_err_sum <= sat_add(r_err_sum, r_abs_err_p1);
         if (r_abs_err_p1 > r_err_max) r_err_max <= r_abs_err_p1;
      end
   end

`ifdef ERR_HIST_EN
   logic [CNT_W-1:0] r_hist [8];
   logic [CNT_W-1:0] r_hist_cnt;
   logic [2:0]       w_bin;

   assign w_bin = (r_abs_err_p1 >= 4'd7) ? 3'd7 : r_abs_err_p1[2:0];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < 8; i++) r_hist[i] <= '0;
         r_hist_cnt <= '0;
      end else begin
         if (w_clear) begin
            for (int i = 0; i < 8; i++) r_hist[i] <= '0;
         end else if (r_vld_p1) begin
            r_hist[w_bin] <= r_hist[w_bin] + CNT_W'(1);
         end
         r_hist_cnt <= r_hist[i_hist_sel];
      end
   end

   assign o_hist_cnt = r_hist_cnt;
`endif

   assign o_in_ready   = r_in_ready;
   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_sample_cnt = r_sample_cnt;
   assign o_err_cnt    = r_err_cnt;
   assign o_err_sum    = r_err_sum;
   assign o_err_max    = r_err_max;

endmodule

// File: tb/tb_adder7_err_monitor.sv
// Directed bench for adder7_err_monitor: a WINDOW=4 instance and a SUM_W=5 saturation instance share stimulus.
module tb_adder7_err_monitor;

   logic        clk;
   logic        rst;
   logic        start;
   logic        in_valid;
   logic [6:0]  in_vec;
   logic [3:0]  in_approx;
   logic        in_ready, busy, done;
   logic [15:0] sample_cnt, err_cnt;
   logic [19:0] err_sum;
   logic [3:0]  err_max;
   logic        s_in_ready, s_busy, s_done;
   logic [15:0] s_sample_cnt, s_err_cnt;
   logic [4:0]  s_err_sum;
   logic [3:0]  s_err_max;
`ifdef ERR_HIST_EN
   logic [2:0]  hist_sel;
   logic [15:0] hist_cnt;
   logic [15:0] s_hist_cnt;
`endif

   int checks = 0;
   int failures = 0;

   adder7_err_monitor #(.WINDOW(4), .CNT_W(16), .SUM_W(20)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_in_valid(in_valid),
      .o_in_ready(in_ready), .i_in_vec(in_vec), .i_in_approx(in_approx),
      .o_busy(busy), .o_done(done), .o_sample_cnt(sample_cnt), .o_err_cnt(err_cnt),
      .o_err_sum(err_sum), .o_err_max(err_max)
`ifdef ERR_HIST_EN
      , .i_hist_sel(hist_sel), .o_hist_cnt(hist_cnt)
`endif
   );

   adder7_err_monitor #(.WINDOW(4), .CNT_W(16), .SUM_W(5)) dut_sat (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_in_valid(in_valid),
      .o_in_ready(s_in_ready), .i_in_vec(in_vec), .i_in_approx(in_approx),
      .o_busy(s_busy), .o_done(s_done), .o_sample_cnt(s_sample_cnt), .o_err_cnt(s_err_cnt),
      .o_err_sum(s_err_sum), .o_err_max(s_err_max)
`ifdef ERR_HIST_EN
      , .i_hist_sel(hist_sel), .o_hist_cnt(s_hist_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic send(input logic [6:0] v, input logic [3:0] a);
      in_valid  = 1'b1;
      in_vec    = v;
      in_approx = a;
      step();
      in_valid  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_vec = '0; in_approx = '0;
`ifdef ERR_HIST_EN
      hist_sel = 3'd0;
`endif
      step(); step();
      checks++; if ({in_ready, busy, done} !== 3'b000) begin $display("FAIL reset_ctrl got=%b exp=000", {in_ready, busy, done}); failures++; end
      checks++; if (sample_cnt !== 16'd0 || err_cnt !== 16'd0) begin $display("FAIL reset_cnt got=%0d/%0d exp=0/0", sample_cnt, err_cnt); failures++; end
      checks++; if (err_sum !== 20'd0 || err_max !== 4'd0) begin $display("FAIL reset_err got=%0d/%0d exp=0/0", err_sum, err_max); failures++; end
      checks++; if (s_err_sum !== 5'd0 || s_in_ready !== 1'b0) begin $display("FAIL reset_sat got=%0d/%b exp=0/0", s_err_sum, s_in_ready); failures++; end
`ifdef ERR_HIST_EN
      checks++; if (hist_cnt !== 16'd0) begin $display("FAIL reset_hist got=%0d exp=0", hist_cnt); failures++; end
`endif
      #2 rst = 1'b0;
      step();
   endtask

   task automatic test_exact();
      do_start();
      checks++; if ({in_ready, busy, done} !== 3'b110) begin $display("FAIL exact_run_status got=%b exp=110", {in_ready, busy, done}); failures++; end
      send(7'h00, 4'd0);
      send(7'h7F, 4'd7);
      send(7'h15, 4'd3);
      send(7'h01, 4'd1);
      checks++; if (in_ready !== 1'b0) begin $display("FAIL exact_ready_drop got=%b exp=0", in_ready); failures++; end
      step();
      checks++; if (done !== 1'b0) begin $display("FAIL exact_done_early got=%b exp=0", done); failures++; end
      step();
      checks++; if ({busy, done} !== 2'b01) begin $display("FAIL exact_done got=%b exp=01", {busy, done}); failures++; end
      checks++; if (sample_cnt !== 16'd4 || err_cnt !== 16'd0) begin $display("FAIL exact_cnt got=%0d/%0d exp=4/0", sample_cnt, err_cnt); failures++; end
      checks++; if (err_sum !== 20'd0 || err_max !== 4'd0) begin $display("FAIL exact_err got=%0d/%0d exp=0/0", err_sum, err_max); failures++; end
   endtask

   task automatic test_errors();
      do_start();
      checks++; if (sample_cnt !== 16'd0 || done !== 1'b0) begin $display("FAIL errors_clear got=%0d/%b exp=0/0", sample_cnt, done); failures++; end
      send(7'h7F, 4'd0);
      send(7'h00, 4'd15);
      send(7'h03, 4'd3);
      send(7'h0F, 4'd4);
      step(); step();
      checks++; if (done !== 1'b1 || sample_cnt !== 16'd4) begin $display("FAIL errors_done got=%b/%0d exp=1/4", done, sample_cnt); failures++; end
      checks++; if (err_cnt !== 16'd3) begin $display("FAIL errors_cnt got=%0d exp=3", err_cnt); failures++; end
      checks++; if (err_sum !== 20'd23) begin $display("FAIL errors_sum got=%0d exp=23", err_sum); failures++; end
      checks++; if (err_max !== 4'd15) begin $display("FAIL errors_max got=%0d exp=15", err_max); failures++; end
      checks++; if (s_err_sum !== 5'd23) begin $display("FAIL errors_sum_narrow got=%0d exp=23", s_err_sum); failures++; end
      step(); step();
      checks++; if (done !== 1'b1 || err_sum !== 20'd23) begin $display("FAIL errors_hold got=%b/%0d exp=1/23", done, err_sum); failures++; end
   endtask

   // Six offers on alternate cycles with errors 1..6; only the first four may land.
   task automatic test_gaps();
      int accepts;
      accepts = 0;
      do_start();
      for (int k = 0; k < 12; k++) begin
         in_valid  = (k % 2 == 0);
         in_vec    = 7'h00;
         in_approx = 4'(k / 2 + 1);
         if (in_valid && in_ready) accepts++;
         step();
         if (k == 6) begin
            checks++; if (in_ready !== 1'b0) begin $display("FAIL gaps_ready_drop got=%b exp=0", in_ready); failures++; end
         end
         if (k == 7) begin
            checks++; if (done !== 1'b0) begin $display("FAIL gaps_done_early got=%b exp=0", done); failures++; end
         end
         if (k == 8) begin
            checks++; if (done !== 1'b1) begin $display("FAIL gaps_done got=%b exp=1", done); failures++; end
         end
      end
      in_valid = 1'b0;
      checks++; if (accepts !== 4) begin $display("FAIL gaps_accepts got=%0d exp=4", accepts); failures++; end
      checks++; if (sample_cnt !== 16'd4 || err_cnt !== 16'd4) begin $display("FAIL gaps_cnt got=%0d/%0d exp=4/4", sample_cnt, err_cnt); failures++; end
      checks++; if (err_sum !== 20'd10 || err_max !== 4'd4) begin $display("FAIL gaps_err got=%0d/%0d exp=10/4", err_sum, err_max); failures++; end
   endtask

   task automatic test_start_valid_sat();
      start = 1'b1; in_valid = 1'b1; in_vec = 7'h00; in_approx = 4'd15;
      step();
      start = 1'b0; in_valid = 1'b0;
      step(); step();
      checks++; if (sample_cnt !== 16'd0 || in_ready !== 1'b1) begin $display("FAIL startvalid_noaccept got=%0d/%b exp=0/1", sample_cnt, in_ready); failures++; end
      start = 1'b1;
      send(7'h00, 4'd15);
      start = 1'b0;
      send(7'h00, 4'd15);
      send(7'h00, 4'd15);
      send(7'h00, 4'd15);
      step(); step();
      checks++; if (done !== 1'b1 || s_done !== 1'b1) begin $display("FAIL sat_done got=%b/%b exp=1/1", done, s_done); failures++; end
      checks++; if (s_err_sum !== 5'd31) begin $display("FAIL sat_sum got=%0d exp=31", s_err_sum); failures++; end
      checks++; if (s_err_cnt !== 16'd4 || s_err_max !== 4'd15) begin $display("FAIL sat_cnt got=%0d/%0d exp=4/15", s_err_cnt, s_err_max); failures++; end
      checks++; if (err_sum !== 20'd60) begin $display("FAIL wide_sum got=%0d exp=60", err_sum); failures++; end
   endtask

   task automatic test_reset_mid();
      do_start();
      send(7'h00, 4'd15);
      send(7'h00, 4'd15);
      step();
      checks++; if (sample_cnt !== 16'd2 || busy !== 1'b1) begin $display("FAIL midrst_pre got=%0d/%b exp=2/1", sample_cnt, busy); failures++; end
      #2 rst = 1'b1;
      #1;
      checks++; if ({in_ready, busy, done} !== 3'b000) begin $display("FAIL midrst_ctrl got=%b exp=000", {in_ready, busy, done}); failures++; end
      checks++; if (sample_cnt !== 16'd0 || err_cnt !== 16'd0 || err_sum !== 20'd0 || err_max !== 4'd0) begin
         $display("FAIL midrst_acc got=%0d/%0d/%0d/%0d exp=0/0/0/0", sample_cnt, err_cnt, err_sum, err_max); failures++; end
      #3 rst = 1'b0;
      step();
      checks++; if ({in_ready, busy, done} !== 3'b000) begin $display("FAIL midrst_idle got=%b exp=000", {in_ready, busy, done}); failures++; end
      do_start();
      send(7'h7F, 4'd5);
      send(7'h07, 4'd3);
      send(7'h3F, 4'd6);
      send(7'h01, 4'd0);
      step(); step();
      checks++; if (done !== 1'b1 || sample_cnt !== 16'd4 || err_cnt !== 16'd2) begin $display("FAIL midrst_clean got=%b/%0d/%0d exp=1/4/2", done, sample_cnt, err_cnt); failures++; end
      checks++; if (err_sum !== 20'd3 || err_max !== 4'd2) begin $display("FAIL midrst_err got=%0d/%0d exp=3/2", err_sum, err_max); failures++; end
   endtask

`ifdef ERR_HIST_EN
   task automatic test_hist();
      logic [15:0] exp_bins [8];
      exp_bins = '{16'd1, 16'd0, 16'd2, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1};
      do_start();
      send(7'h00, 4'd0);
      send(7'h00, 4'd2);
      send(7'h00, 4'd9);
      send(7'h01, 4'd3);
      step(); step();
      for (int b = 0; b < 8; b++) begin
         hist_sel = 3'(b);
         step();
         checks++; if (hist_cnt !== exp_bins[b]) begin $display("FAIL hist_bin%0d got=%0d exp=%0d", b, hist_cnt, exp_bins[b]); failures++; end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_exact();
      test_errors();
      test_gaps();
      test_start_valid_sat();
      test_reset_mid();
`ifdef ERR_HIST_EN
      test_hist();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
